// File: rtl/mc_control_pkg.sv
// Shared definitions for the TSC multi-cycle control slice: ISA opcode and
// function codes, FSM state encoding, datapath mux select encodings and the
// instruction-class flags produced by mc_decode.
// Optional feature macro: DMA_GRANT_EN (adds the BG bus-grant state).
package mc_control_pkg;

  localparam int WORD_SIZE = 16;

  // Opcodes (IR[15:12])
  localparam logic [3:0] BNE_OP = 4'd0;
  localparam logic [3:0] BEQ_OP = 4'd1;
  localparam logic [3:0] BGZ_OP = 4'd2;
  localparam logic [3:0] BLZ_OP = 4'd3;
  localparam logic [3:0] ADI_OP = 4'd4;
  localparam logic [3:0] ORI_OP = 4'd5;
  localparam logic [3:0] LHI_OP = 4'd6;
  localparam logic [3:0] LWD_OP = 4'd7;
  localparam logic [3:0] SWD_OP = 4'd8;
  localparam logic [3:0] JMP_OP = 4'd9;
  localparam logic [3:0] JAL_OP = 4'd10;
  localparam logic [3:0] ALU_OP = 4'd15;

  // Function codes (IR[5:0]) under ALU_OP
  localparam logic [5:0] FUNC_ADD = 6'd0;
  localparam logic [5:0] FUNC_SUB = 6'd1;
  localparam logic [5:0] FUNC_AND = 6'd2;
  localparam logic [5:0] FUNC_ORR = 6'd3;
  localparam logic [5:0] FUNC_NOT = 6'd4;
  localparam logic [5:0] FUNC_TCP = 6'd5;
  localparam logic [5:0] FUNC_SHL = 6'd6;
  localparam logic [5:0] FUNC_SHR = 6'd7;
  localparam logic [5:0] FUNC_JPR = 6'd25;
  localparam logic [5:0] FUNC_JRL = 6'd26;
  localparam logic [5:0] FUNC_WWD = 6'd28;
  localparam logic [5:0] FUNC_HLT = 6'd29;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
`ifdef DMA_GRANT_EN
    ,
    ST_BG   = 3'd6
`endif
  } state_t;

  typedef enum logic [1:0] {
    PC_SRC_ALU    = 2'd0,
    PC_SRC_ALUOUT = 2'd1,
    PC_SRC_JUMP   = 2'd2,
    PC_SRC_RS     = 2'd3
  } pc_src_t;

  typedef enum logic {
    SRC_A_PC = 1'b0,
    SRC_A_RS = 1'b1
  } alu_src_a_t;

  typedef enum logic [1:0] {
    SRC_B_RT  = 2'd0,
    SRC_B_ONE = 2'd1,
    SRC_B_IMM = 2'd2
  } alu_src_b_t;

  typedef enum logic [1:0] {
    DST_RT = 2'd0,
    DST_RD = 2'd1,
    DST_R2 = 2'd2
  } reg_dst_t;

  typedef enum logic [1:0] {
    M2R_ALUOUT = 2'd0,
    M2R_MDR    = 2'd1,
    M2R_PC     = 2'd2
  } mem_to_reg_t;

  // At most one flag is set; all clear means an undefined encoding (NOP).
  typedef struct packed {
    logic is_rtype;
    logic is_imm;
    logic is_lwd;
    logic is_swd;
    logic is_branch;
    logic is_jmp;
    logic is_jal;
    logic is_jpr;
    logic is_jrl;
    logic is_wwd;
    logic is_hlt;
  } inst_class_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/func_code to instruction-class decode for mc_control.
module mc_decode
  import mc_control_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [5:0]  func_code,
  output inst_class_t cls
);

  // Map the current IR fields onto one instruction-class flag
  always_comb begin
    cls = '0;
    case (opcode)
      BNE_OP, BEQ_OP, BGZ_OP, BLZ_OP: cls.is_branch = 1'b1;
      ADI_OP, ORI_OP, LHI_OP:         cls.is_imm    = 1'b1;
      LWD_OP:                         cls.is_lwd    = 1'b1;
      SWD_OP:                         cls.is_swd    = 1'b1;
      JMP_OP:                         cls.is_jmp    = 1'b1;
      JAL_OP:                         cls.is_jal    = 1'b1;
      ALU_OP: begin
        case (func_code)
          FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_ORR,
          FUNC_NOT, FUNC_TCP, FUNC_SHL, FUNC_SHR: cls.is_rtype = 1'b1;
          FUNC_JPR:                               cls.is_jpr   = 1'b1;
          FUNC_JRL:                               cls.is_jrl   = 1'b1;
          FUNC_WWD:                               cls.is_wwd   = 1'b1;
          FUNC_HLT:                               cls.is_hlt   = 1'b1;
          default:                                ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control FSM for the 16-bit TSC core. Sequences the shared ALU
// through IF/ID/EX/MEM/WB, drives datapath muxes/enables and handshakes with
// unified memory via mem_req/mem_ack. Counts retired instructions.
// Optional feature macro: DMA_GRANT_EN adds dma_req/dma_grant and a BG state
// that defers new memory accesses while DMA owns the bus.
module mc_control
  import mc_control_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 Reset_N,
  input  logic [3:0]           opcode,
  input  logic [5:0]           func_code,
  input  logic                 bcond,
  input  logic                 mem_ack,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic                 i_or_d,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [3:0]           alu_opcode,
  output logic [5:0]           alu_func,
  output logic                 reg_write,
  output logic [1:0]           reg_dst,
  output logic [1:0]           mem_to_reg,
  output logic                 wwd_valid,
  output logic                 is_halted,
`ifdef DMA_GRANT_EN
  input  logic                 dma_req,
  output logic                 dma_grant,
`endif
  output logic [CNT_WIDTH-1:0] num_inst
);

  state_t      state;
  state_t      nxt;
  state_t      nxt_fsm;
  logic        count;
  inst_class_t cls;
`ifdef DMA_GRANT_EN
  state_t      pend_state;
`endif

  mc_decode u_decode (
    .opcode    (opcode),
    .func_code (func_code),
    .cls       (cls)
  );

  // State register and retired-instruction counter; reset wins over a count
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!Reset_N) begin
      state    <= ST_IF;
      num_inst <= '0;
    end else begin
      state    <= nxt;
      num_inst <= num_inst + CNT_WIDTH'(count);
    end
  end

`ifdef DMA_GRANT_EN
  // Remember which access was deferred so BG can resume it
  always_ff @(posedge clk) begin
    if (!Reset_N) begin
      pend_state <= ST_IF;
    end else if (nxt == ST_BG && state != ST_BG) begin
      pend_state <= nxt_fsm;
    end
  end
`endif

  // Next-state and Moore outputs; EX branch pc_write and IF latch enables follow inputs
  always_comb begin
    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    nxt_fsm    = state;
    nxt        = state;
    count      = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_ALU;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RT;
    alu_opcode = 4'd0;
    alu_func   = 6'd0;
    reg_write  = 1'b0;
    reg_dst    = DST_RT;
    mem_to_reg = M2R_ALUOUT;
    wwd_valid  = 1'b0;
    is_halted  = 1'b0;
`ifdef DMA_GRANT_EN
    dma_grant  = 1'b0;
`endif

    case (state)
      ST_IF: begin
        mem_req    = 1'b1;
        alu_opcode = ADI_OP;
        alu_src_b  = SRC_B_ONE;
        if (mem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          nxt_fsm  = ST_ID;
        end
      end

      ST_ID: begin
        // PC+imm is latched into ALUOut as the branch target for EX
        alu_opcode = ADI_OP;
        alu_src_b  = SRC_B_IMM;
        nxt_fsm    = ST_EX;
        if (cls.is_jmp || cls.is_jal) begin
          pc_write = 1'b1;
          pc_src   = PC_SRC_JUMP;
          count    = 1'b1;
          nxt_fsm  = ST_IF;
          if (cls.is_jal) begin
            reg_write  = 1'b1;
            reg_dst    = DST_R2;
            mem_to_reg = M2R_PC;
          end
        end
      end

      ST_EX: begin
        alu_opcode = opcode;
        alu_func   = func_code;
        alu_src_a  = SRC_A_RS;
        if (cls.is_imm || cls.is_lwd || cls.is_swd) begin
          alu_src_b = SRC_B_IMM;
        end
        if (cls.is_branch) begin
          pc_write = bcond;
          pc_src   = PC_SRC_ALUOUT;
          count    = 1'b1;
          nxt_fsm  = ST_IF;
        end else if (cls.is_jpr || cls.is_jrl) begin
          pc_write = 1'b1;
          pc_src   = PC_SRC_RS;
          count    = 1'b1;
          nxt_fsm  = ST_IF;
          if (cls.is_jrl) begin
            reg_write  = 1'b1;
            reg_dst    = DST_R2;
            mem_to_reg = M2R_PC;
          end
        end else if (cls.is_wwd) begin
          wwd_valid = 1'b1;
          count     = 1'b1;
          nxt_fsm   = ST_IF;
        end else if (cls.is_hlt) begin
          count   = 1'b1;
          nxt_fsm = ST_HALT;
        end else if (cls.is_lwd || cls.is_swd) begin
          nxt_fsm = ST_MEM;
        end else if (cls.is_rtype || cls.is_imm) begin
          nxt_fsm = ST_WB;
        end else begin
          // Undefined encoding retires as a NOP
          count   = 1'b1;
          nxt_fsm = ST_IF;
        end
      end

      ST_MEM: begin
        mem_req   = 1'b1;
        i_or_d    = 1'b1;
        mem_write = cls.is_swd;
        if (mem_ack) begin
          if (cls.is_swd) begin
            count   = 1'b1;
            nxt_fsm = ST_IF;
          end else begin
            nxt_fsm = ST_WB;
          end
        end
      end

      ST_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (opcode == ALU_OP) ? DST_RD : DST_RT;
        mem_to_reg = cls.is_lwd ? M2R_MDR : M2R_ALUOUT;
        count      = 1'b1;
        nxt_fsm    = ST_IF;
      end

      ST_HALT: begin
        is_halted = 1'b1;
        nxt_fsm   = ST_HALT;
      end

`ifdef DMA_GRANT_EN
      ST_BG: begin
        dma_grant = 1'b1;
        nxt_fsm   = dma_req ? ST_BG : pend_state;
      end
`endif

      default: nxt_fsm = ST_IF;
    endcase

    nxt = nxt_fsm;

`ifdef DMA_GRANT_EN
    // Entering IF or MEM starts a new access; park in BG instead while DMA asks for the bus
    if (dma_req && state != ST_BG &&
        ((nxt_fsm == ST_IF && state != ST_IF) || (nxt_fsm == ST_MEM && state != ST_MEM))) begin
      nxt = ST_BG;
    end
`endif

    // A reset cycle abandons the current step: no architectural writes
    if (!Reset_N) begin
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      wwd_valid = 1'b0;
      count     = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed vector table, hand-written
// multi-cycle corner sequences and randomized instructions checked against a
// per-instruction behavioural model (latency and write events).
module tb_mc_control;

  localparam int CW = 6;  // small counter so random runs wrap it

  localparam logic [3:0] OP_BNE = 4'd0, OP_BEQ = 4'd1, OP_ADI = 4'd4, OP_LHI = 4'd6;
  localparam logic [3:0] OP_LWD = 4'd7, OP_SWD = 4'd8, OP_JMP = 4'd9, OP_JAL = 4'd10;
  localparam logic [3:0] OP_ALU = 4'd15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          Reset_N;
  logic [3:0]    opcode;
  logic [5:0]    func_code;
  logic          bcond;
  logic          mem_ack;
  logic          mem_req, mem_write, i_or_d, ir_write, pc_write;
  logic [1:0]    pc_src;
  logic          alu_src_a;
  logic [1:0]    alu_src_b;
  logic [3:0]    alu_opcode;
  logic [5:0]    alu_func;
  logic          reg_write;
  logic [1:0]    reg_dst, mem_to_reg;
  logic          wwd_valid, is_halted;
  logic [CW-1:0] num_inst;
`ifdef DMA_GRANT_EN
  logic          dma_req;
  logic          dma_grant;
`endif

  mc_control #(.CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .Reset_N    (Reset_N),
    .opcode     (opcode),
    .func_code  (func_code),
    .bcond      (bcond),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .i_or_d     (i_or_d),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_opcode (alu_opcode),
    .alu_func   (alu_func),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .wwd_valid  (wwd_valid),
    .is_halted  (is_halted),
`ifdef DMA_GRANT_EN
    .dma_req    (dma_req),
    .dma_grant  (dma_grant),
`endif
    .num_inst   (num_inst)
  );

  typedef struct {
    int cyc;   // cycles from entering IF until the next IF (or HALT)
    int pcw;   // pc_write pulses
    int rw;    // reg_write pulses
    int dst;   // reg_dst at the register write
    int m2r;   // mem_to_reg at the register write
    int memw;  // completed memory writes
    int wwd;   // wwd_valid pulses
    int halt;  // ends in HALT
  } exp_t;

  typedef struct {
    logic [3:0] op;
    logic [5:0] fn;
    bit         bc;
    int         iw;
    int         mw;
    exp_t       e;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  int o_cyc, o_pcw, o_irw, o_rw, o_dst, o_m2r, o_memw, o_wwd, o_halt, o_mem_cyc;
  int o_ex_op, o_ex_fn, o_ex_pcw, o_ex_pcsrc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: what one instruction must do, from the ISA-level rules
  function automatic exp_t model(input logic [3:0] op, input logic [5:0] fn,
                                 input bit bc, input int iw, input int mw);
    exp_t e;
    e = '{cyc: 3, pcw: 1, rw: 0, dst: 0, m2r: 0, memw: 0, wwd: 0, halt: 0};
    if (op == OP_JMP) begin
      e.cyc = 2; e.pcw = 2;
    end else if (op == OP_JAL) begin
      e.cyc = 2; e.pcw = 2; e.rw = 1; e.dst = 2; e.m2r = 2;
    end else if (op <= 4'd3) begin
      e.pcw = bc ? 2 : 1;
    end else if (op >= 4'd4 && op <= 4'd6) begin
      e.cyc = 4; e.rw = 1;
    end else if (op == OP_LWD) begin
      e.cyc = 5 + mw; e.rw = 1; e.m2r = 1;
    end else if (op == OP_SWD) begin
      e.cyc = 4 + mw; e.memw = 1;
    end else if (op == OP_ALU) begin
      if (fn <= 6'd7) begin
        e.cyc = 4; e.rw = 1; e.dst = 1;
      end else if (fn == 6'd25) begin
        e.pcw = 2;
      end else if (fn == 6'd26) begin
        e.pcw = 2; e.rw = 1; e.dst = 2; e.m2r = 2;
      end else if (fn == 6'd28) begin
        e.wwd = 1;
      end else if (fn == 6'd29) begin
        e.halt = 1;
      end
    end
    e.cyc += iw;
    return e;
  endfunction

  function automatic vec_t mk(input logic [3:0] op, input logic [5:0] fn, input bit bc,
                              input int iw, input int mw, input int cyc, input int pcw,
                              input int rw, input int dst, input int m2r, input int memw,
                              input int wwd);
    vec_t v;
    v.op = op; v.fn = fn; v.bc = bc; v.iw = iw; v.mw = mw;
    v.e = '{cyc: cyc, pcw: pcw, rw: rw, dst: dst, m2r: m2r, memw: memw, wwd: wwd, halt: 0};
    return v;
  endfunction

  // Run one instruction starting just after a posedge in IF; memory acks after iw/mw waits
  task automatic run_inst(input logic [3:0] op, input logic [5:0] fn, input bit bc,
                          input int iw, input int mw);
    int  wctr;
    bit  left_if;
    bit  done;
    opcode = op; func_code = fn; bcond = bc;
    o_cyc = 0; o_pcw = 0; o_irw = 0; o_rw = 0; o_dst = 0; o_m2r = 0; o_memw = 0;
    o_wwd = 0; o_halt = 0; o_mem_cyc = 0; o_ex_op = -1; o_ex_fn = -1; o_ex_pcw = -1;
    o_ex_pcsrc = -1;
    wctr = 0; left_if = 0; done = 0;
    while (!done) begin
      mem_ack = mem_req && (wctr >= (i_or_d ? mw : iw));
      @(negedge clk);
      if (mem_req && i_or_d) o_mem_cyc++;
      if (pc_write) o_pcw++;
      if (ir_write) begin o_irw++; left_if = 1; end
      if (reg_write) begin o_rw++; o_dst = reg_dst; o_m2r = mem_to_reg; end
      if (mem_req && mem_write && mem_ack) o_memw++;
      if (wwd_valid) o_wwd++;
      if (alu_src_a) begin
        o_ex_op = alu_opcode; o_ex_fn = alu_func; o_ex_pcw = pc_write; o_ex_pcsrc = pc_src;
      end
      wctr = (mem_req && !mem_ack) ? wctr + 1 : 0;
      @(posedge clk); #1;
      o_cyc++;
      if (is_halted) begin
        o_halt = 1; done = 1;
      end else if (left_if && mem_req && !i_or_d) begin
        done = 1;
      end else if (o_cyc >= 40) begin
        total++; bad++;
        $display("FAIL timeout: op=%0d fn=%0d did not return to IF in 40 cycles", op, fn);
        done = 1;
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic compare_obs(input string tag, input exp_t e);
    check({tag, " cycles"},     o_cyc,  e.cyc);
    check({tag, " ir_write"},   o_irw,  1);
    check({tag, " pc_write"},   o_pcw,  e.pcw);
    check({tag, " reg_write"},  o_rw,   e.rw);
    check({tag, " reg_dst"},    o_dst,  e.dst);
    check({tag, " mem_to_reg"}, o_m2r,  e.m2r);
    check({tag, " mem_write"},  o_memw, e.memw);
    check({tag, " wwd_valid"},  o_wwd,  e.wwd);
    check({tag, " halted"},     o_halt, e.halt);
    exp_cnt++;
    check({tag, " num_inst"},   num_inst, exp_cnt % (1 << CW));
  endtask

  task automatic do_reset();
    Reset_N = 1'b0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 Reset_N = 1'b1;
    exp_cnt = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    logic [5:0] fn_pool [0:15];
    int mreq_cnt;
    int frozen;

    opcode = 4'd0; func_code = 6'd0; bcond = 1'b0; mem_ack = 1'b0;
`ifdef DMA_GRANT_EN
    dma_req = 1'b0;
`endif
    do_reset();

    // Reset state: IF fetch signature, nothing written, counter clear
    @(negedge clk);
    check("reset mem_req",    mem_req,    1);
    check("reset i_or_d",     i_or_d,     0);
    check("reset alu_opcode", alu_opcode, 4);
    check("reset alu_src_a",  alu_src_a,  0);
    check("reset alu_src_b",  alu_src_b,  1);
    check("reset ir_write",   ir_write,   0);
    check("reset reg_write",  reg_write,  0);
    check("reset is_halted",  is_halted,  0);
    check("reset num_inst",   num_inst,   0);
    @(posedge clk); #1;

    // ADD with zero-wait memory
    run_inst(OP_ALU, 6'd0, 1'b0, 0, 0);
    check("add ex alu_opcode", o_ex_op, 15);
    check("add ex alu_func",   o_ex_fn, 0);
    compare_obs("add", model(OP_ALU, 6'd0, 1'b0, 0, 0));

    // Directed table: expected values derived by hand from the latency rules
    vecs.push_back(mk(OP_ALU, 6'd1,  0, 2, 0, 6, 1, 1, 1, 0, 0, 0));  // SUB, 2 IF waits
    vecs.push_back(mk(OP_ADI, 6'd0,  0, 0, 0, 4, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(OP_LHI, 6'd9,  0, 1, 0, 5, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(OP_LWD, 6'd0,  0, 0, 0, 5, 1, 1, 0, 1, 0, 0));
    vecs.push_back(mk(OP_SWD, 6'd0,  0, 1, 1, 6, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(OP_BNE, 6'd0,  1, 0, 0, 3, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_BEQ, 6'd0,  0, 0, 0, 3, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_JMP, 6'd0,  0, 0, 0, 2, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_JAL, 6'd0,  0, 1, 0, 3, 2, 1, 2, 2, 0, 0));
    vecs.push_back(mk(OP_ALU, 6'd25, 0, 0, 0, 3, 2, 0, 0, 0, 0, 0));  // JPR
    vecs.push_back(mk(OP_ALU, 6'd26, 0, 0, 0, 3, 2, 1, 2, 2, 0, 0));  // JRL
    vecs.push_back(mk(OP_ALU, 6'd28, 0, 0, 0, 3, 1, 0, 0, 0, 0, 1));  // WWD
    vecs.push_back(mk(4'd12,  6'd0,  0, 0, 0, 3, 1, 0, 0, 0, 0, 0));  // undefined opcode
    vecs.push_back(mk(OP_ALU, 6'd40, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0));  // undefined func
    for (int i = 0; i < vecs.size(); i++) begin
      run_inst(vecs[i].op, vecs[i].fn, vecs[i].bc, vecs[i].iw, vecs[i].mw);
      compare_obs($sformatf("vec%0d", i), vecs[i].e);
    end

    // LWD with three wait cycles in MEM
    run_inst(OP_LWD, 6'd0, 1'b0, 0, 3);
    check("lwd mem cycles", o_mem_cyc, 4);
    compare_obs("lwd_wait", '{cyc: 8, pcw: 1, rw: 1, dst: 0, m2r: 1, memw: 0, wwd: 0, halt: 0});

    // BEQ taken / not taken: EX-cycle pc_write follows bcond
    run_inst(OP_BEQ, 6'd0, 1'b1, 0, 0);
    check("beq1 ex pc_write", o_ex_pcw, 1);
    check("beq1 ex pc_src",   o_ex_pcsrc, 1);
    compare_obs("beq1", model(OP_BEQ, 6'd0, 1'b1, 0, 0));
    run_inst(OP_BEQ, 6'd0, 1'b0, 0, 0);
    check("beq0 ex pc_write", o_ex_pcw, 0);
    compare_obs("beq0", model(OP_BEQ, 6'd0, 1'b0, 0, 0));

    // Randomized instructions against the model (HLT excluded; counter wraps)
    fn_pool = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7,
                6'd25, 6'd26, 6'd28, 6'd8, 6'd20, 6'd27, 6'd40, 6'd63};
    for (int n = 0; n < 150; n++) begin
      logic [3:0] op;
      logic [5:0] fn;
      bit bc;
      int iw, mw;
      op = 4'($urandom_range(0, 15));
      fn = (op == OP_ALU) ? fn_pool[$urandom_range(0, 15)] : 6'($urandom_range(0, 63));
      bc = 1'($urandom_range(0, 1));
      iw = $urandom_range(0, 2);
      mw = $urandom_range(0, 2);
      run_inst(op, fn, bc, iw, mw);
      compare_obs($sformatf("rnd%0d op%0d fn%0d", n, op, fn), model(op, fn, bc, iw, mw));
    end

    // HLT: sticky halt, no fetches, counter frozen; then a one-cycle reset
    run_inst(OP_ALU, 6'd29, 1'b0, 0, 0);
    compare_obs("hlt", model(OP_ALU, 6'd29, 1'b0, 0, 0));
    frozen = num_inst;
    mreq_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_req || !is_halted) mreq_cnt++;
      @(posedge clk); #1;
    end
    check("halt idle cycles violated", mreq_cnt, 0);
    check("halt num_inst frozen", num_inst, frozen);
    Reset_N = 1'b0;
    @(posedge clk); #1 Reset_N = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
    check("post-halt reset is_halted", is_halted, 0);
    check("post-halt reset mem_req",   mem_req, 1);
    check("post-halt reset i_or_d",    i_or_d, 0);
    check("post-halt reset num_inst",  num_inst, 0);
    @(posedge clk); #1;

    // Reset during IF with mem_ack low: no latch enables, fetch restarts
    Reset_N = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    check("rst-if ir_write", ir_write, 0);
    check("rst-if pc_write", pc_write, 0);
    @(posedge clk); #1 Reset_N = 1'b1;
    @(negedge clk);
    check("rst-if mem_req after", mem_req, 1);
    check("rst-if i_or_d after",  i_or_d, 0);
    @(posedge clk); #1;

    // Reset in the MEM state of a load: access abandoned, no register write
    opcode = OP_LWD; func_code = 6'd0; mem_ack = 1'b1;
    @(posedge clk); #1 mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 Reset_N = 1'b0;
    @(negedge clk);
    check("rst-mem in MEM", {31'd0, mem_req & i_or_d}, 1);
    @(posedge clk); #1 Reset_N = 1'b1;
    @(negedge clk);
    check("rst-mem back in IF", {30'd0, mem_req, i_or_d}, 2);
    check("rst-mem reg_write",  reg_write, 0);
    check("rst-mem num_inst",   num_inst, 0);
    @(posedge clk); #1;

`ifdef DMA_GRANT_EN
    // DMA request raised in ID of SWD defers MEM until it drops
    do_reset();
    opcode = OP_SWD; func_code = 6'd0; mem_ack = 1'b1;
    @(posedge clk); #1 mem_ack = 1'b0; dma_req = 1'b1;      // now in ID
    @(posedge clk); #1;                                      // now in EX
    @(negedge clk);
    check("dma ex alu_src_a", alu_src_a, 1);
    check("dma ex grant",     dma_grant, 0);
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("dma grant c%0d", c), {30'd0, dma_grant, mem_req}, 2);
      @(posedge clk); #1;
    end
    dma_req = 1'b0;
    @(negedge clk);
    check("dma grant on fall", dma_grant, 1);
    @(posedge clk); #1 mem_ack = 1'b1;
    @(negedge clk);
    check("dma mem resumed", {29'd0, mem_req, i_or_d, mem_write}, 7);
    check("dma grant in MEM", dma_grant, 0);
    @(posedge clk); #1 mem_ack = 1'b0;
    @(negedge clk);
    check("dma swd retired", num_inst, 1);
    check("dma back in IF", {30'd0, mem_req, i_or_d}, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
